hazard_ctrl_unit: RTL

Pipeline hazard controller for the five-stage core: a generalised successor to the forwarding control unit. Adds the following to E-stage operand forwarding from M/W:
- load-use stall detection against the D-stage instruction;
- branch/jump flush generation;
- a counter-driven stall FSM that holds the pipeline while a fixed-latency multi-cycle op (mul/div) occupies X.

Sits beside the pipeline registers and drives their stall/flush enables plus the E-stage operand mux selects.

---
 rtl/hazard_ctrl_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: E-stage forwarding, load-use stall, branch flush and multi-cycle-op stall control
//   inputs : clk, rst_n (async, active low), instr_d/x/m/w, asel_x/bsel_x, regwen_x/m/w,
//            memrd_x, br_taken_x, mc_start_x
//   outputs: asel_fcu/bsel_fcu (operand mux selects), stall_f/d/x, flush_d/x/m, busy,
//            stall_cnt/flush_cnt (perf counters, present only with HAZARD_PERF_EN defined)
module hazard_ctrl_unit #(
    parameter int AWIDTH = 32,
    parameter int RADDR  = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] instr_d,
    input  logic [AWIDTH-1:0] instr_x,
    input  logic [AWIDTH-1:0] instr_m,
    input  logic [AWIDTH-1:0] instr_w,
    input  logic [1:0]        asel_x,
    input  logic [1:0]        bsel_x,
    input  logic              regwen_x,
    input  logic              regwen_m,
    input  logic              regwen_w,
    input  logic              memrd_x,
    input  logic              br_taken_x,
    input  logic              mc_start_x,
    output logic [1:0]        asel_fcu,
    output logic [1:0]        bsel_fcu,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_x,
    output logic              flush_d,
    output logic              flush_x,
    output logic              flush_m,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic {RUN, MC_BUSY} state_t;
    localparam bit MC_EN = MC_LAT >= 2;
    state_t state;
    logic [3:0] mc_cnt;
    logic [RADDR-1:0] rs1_d, rs2_d, rd_x, rs1_x, rs2_x, rd_m, rd_w;
    logic run, br, mc_go, lu, unused_bits;
    assign rs1_d = instr_d[15+:RADDR];
    assign rs2_d = instr_d[20+:RADDR];
    assign rd_x  = instr_x[7+:RADDR];
    assign rs1_x = instr_x[15+:RADDR];
    assign rs2_x = instr_x[20+:RADDR];
    assign rd_m  = instr_m[7+:RADDR];
    assign rd_w  = instr_w[7+:RADDR];
    assign unused_bits = ^{instr_d, instr_x, instr_m, instr_w};
    assign asel_fcu = (regwen_m && rd_m != '0 && rd_m == rs1_x) ? 2'b10 :
                      (regwen_w && rd_w != '0 && rd_w == rs1_x) ? 2'b11 : asel_x;
    assign bsel_fcu = (regwen_m && rd_m != '0 && rd_m == rs2_x) ? 2'b10 :
                      (regwen_w && rd_w != '0 && rd_w == rs2_x) ? 2'b11 : bsel_x;
    assign run   = state == RUN;
    assign busy  = state == MC_BUSY;
    // In RUN a taken branch outranks a multi-cycle start, which outranks load-use
    assign br    = run && br_taken_x;
    assign mc_go = run && MC_EN && mc_start_x && !br_taken_x;
    assign lu    = run && !br_taken_x && !mc_go && memrd_x && regwen_x && rd_x != '0 &&
                   (rd_x == rs1_d || rd_x == rs2_d);
    assign stall_f = busy || mc_go || lu;
    assign stall_d = stall_f;
    assign stall_x = busy || mc_go;
    assign flush_m = stall_x;
    assign flush_d = br;
    assign flush_x = br || lu;
    // The start cycle itself is the first stall, so mc_cnt holds the remaining busy cycles
    // (MC_LAT-2); with MC_LAT == 2 the single start-cycle stall is enough and MC_BUSY is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else if (run) begin
            if (mc_go && MC_LAT > 2) begin
                state  <= MC_BUSY;
                mc_cnt <= 4'(MC_LAT - 2);
            end
        end else begin
            mc_cnt <= mc_cnt - 4'd1;
            if (mc_cnt <= 4'd1) state <= RUN;
        end
    end
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if ((flush_d || flush_x) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
